// File: rtl/pwr_btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwr_btn_pkg
// Description : Shared definitions for the front-panel power-button
//               conditioner: FSM state encoding, default timing constants
//               and button / output polarity constants.
// Revision    : 1.0 - initial release
// ============================================================================
package pwr_btn_pkg;

  // FSM state encoding; the numeric values are visible on FsmState.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PULSE   = 3'd1,
    ST_HELD    = 3'd2,
    ST_LONG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } btn_state_t;

  // Default timing (units: Strobe1ms ticks, except LONG_PRESS_T in Strobe125ms ticks).
  localparam int C_SYNC_STAGES  = 2;
  localparam int C_DEBOUNCE_MS  = 16;
  localparam int C_MIN_PULSE_MS = 100;
  localparam int C_LONG_PRESS_T = 32;
  localparam int C_LOCKOUT_MS   = 250;

  // Polarity of the raw button and of the conditioned output (both active low).
  localparam logic C_BTN_PRESSED_N  = 1'b0;
  localparam logic C_BTN_RELEASED_N = 1'b1;
  localparam logic C_OUT_ASSERTED   = 1'b0;
  localparam logic C_OUT_DEASSERTED = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_btn_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : pwr_btn_debounce_if
// Description : Signal bundle between the button conditioner and its
//               environment.
//               slave  : conditioner side (strobes/button/enable in,
//                        conditioned button, long-press pulse, debounced
//                        level and FSM state out)
//               master : environment side (mirror image)
// Revision    : 1.0 - initial release
// ============================================================================
interface pwr_btn_debounce_if;
  import pwr_btn_pkg::*;

  logic       Strobe1ms;
  logic       Strobe125ms;
  logic       PWR_BTN_IN_N;
  logic       BtnEnable;
  logic       PowerButtonOut_ox;
  logic       LongPressEvt;
  logic       BtnPressedDb;
  btn_state_t FsmState;

  modport master (
    output Strobe1ms, Strobe125ms, PWR_BTN_IN_N, BtnEnable,
    input  PowerButtonOut_ox, LongPressEvt, BtnPressedDb, FsmState
  );

  modport slave (
    input  Strobe1ms, Strobe125ms, PWR_BTN_IN_N, BtnEnable,
    output PowerButtonOut_ox, LongPressEvt, BtnPressedDb, FsmState
  );

endinterface
`default_nettype wire

// File: rtl/strobe_debounce.sv
`default_nettype none
// ============================================================================
// Module      : strobe_debounce
// Description : Synchroniser plus strobe-timed debouncer for an active-low
//               asynchronous push button.
//               clk        : system clock
//               rst        : synchronous active-high reset
//               strobe_1ms : one-clock enable every 1 ms
//               btn_in_n   : raw button, active low, asynchronous
//               pressed    : debounced level, 1 = pressed
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_debounce
  import pwr_btn_pkg::*;
#(
  parameter int SYNC_STAGES = C_SYNC_STAGES,
  parameter int DEBOUNCE_MS = C_DEBOUNCE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_1ms,
  input  logic btn_in_n,
  output logic pressed
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pressed;
  logic                   w_sync_pressed;

  assign w_sync_pressed = (r_sync[SYNC_STAGES-1] == C_BTN_PRESSED_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= {SYNC_STAGES{C_BTN_RELEASED_N}};
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in_n};
      if (w_sync_pressed == r_pressed) begin
        // Input agrees with the debounced level: any partial count is a bounce.
        r_cnt <= '0;
      end else if (strobe_1ms) begin
        // Toggle on the strobe that completes DEBOUNCE_MS stable ticks.
        if (r_cnt >= C_CNT_LAST) begin
          r_pressed <= ~r_pressed;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign pressed = r_pressed;

endmodule
`default_nettype wire

// File: rtl/pwr_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pwr_btn_debounce
// Description : Front-panel power-button conditioner. Debounces the raw
//               button, then generates an active-low strobe with a minimum
//               width, flags long presses and applies a post-release lockout.
//               SysClk   : system clock
//               SysReset : synchronous active-high reset
//               bus      : Strobe1ms/Strobe125ms/PWR_BTN_IN_N/BtnEnable in;
//                          PowerButtonOut_ox/LongPressEvt/BtnPressedDb/
//                          FsmState out
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_btn_debounce
  import pwr_btn_pkg::*;
#(
  parameter int SYNC_STAGES  = C_SYNC_STAGES,
  parameter int DEBOUNCE_MS  = C_DEBOUNCE_MS,
  parameter int MIN_PULSE_MS = C_MIN_PULSE_MS,
  parameter int LONG_PRESS_T = C_LONG_PRESS_T,
  parameter int LOCKOUT_MS   = C_LOCKOUT_MS
) (
  input  logic              SysClk,
  input  logic              SysReset,
  pwr_btn_debounce_if.slave bus
);

  // The ms timer is shared between PULSE and LOCKOUT, so it is sized for the larger.
  localparam int              MS_MAX        = max2(MIN_PULSE_MS, LOCKOUT_MS);
  localparam int              MS_W          = $clog2(MS_MAX + 1);
  localparam int              LP_W          = $clog2(LONG_PRESS_T + 1);
  localparam logic [MS_W-1:0] C_MS_SAT      = MS_W'(MS_MAX);
  localparam logic [MS_W-1:0] C_PULSE_END   = MS_W'(MIN_PULSE_MS);
  localparam logic [MS_W-1:0] C_LOCKOUT_END = MS_W'(LOCKOUT_MS);
  localparam logic [LP_W-1:0] C_LONG_END    = LP_W'(LONG_PRESS_T);

  logic            w_pressed;
  btn_state_t      r_state;
  logic [MS_W-1:0] r_ms;
  logic [LP_W-1:0] r_lp;
  logic            r_pressed_d;
  logic            r_out_n;
  logic            r_long_evt;

  logic [MS_W-1:0] w_ms_next;
  logic [LP_W-1:0] w_lp_next;
  logic            w_rise;
  logic            w_long_hit;

  strobe_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debounce (
    .clk        (SysClk),
    .rst        (SysReset),
    .strobe_1ms (bus.Strobe1ms),
    .btn_in_n   (bus.PWR_BTN_IN_N),
    .pressed    (w_pressed)
  );

  // Saturating next values of both timers; each advances on its own strobe,
  // so coincident strobes move both.
  always_comb begin
    w_ms_next = r_ms;
    if (bus.Strobe1ms && (r_ms != C_MS_SAT)) begin
      w_ms_next = r_ms + 1'b1;
    end
    w_lp_next = r_lp;
    if (bus.Strobe125ms && (r_lp != C_LONG_END)) begin
      w_lp_next = r_lp + 1'b1;
    end
  end

  assign w_rise = w_pressed & ~r_pressed_d;

  // Threshold only counts while the button is still down, so a release in the
  // same cycle suppresses the long-press event.
  assign w_long_hit = w_pressed && (r_lp != C_LONG_END) && (w_lp_next == C_LONG_END);

  always_ff @(posedge SysClk) begin
    if (SysReset) begin
      r_state     <= ST_IDLE;
      r_ms        <= '0;
      r_lp        <= '0;
      r_pressed_d <= 1'b0;
      r_out_n     <= C_OUT_DEASSERTED;
      r_long_evt  <= 1'b0;
    end else begin
      r_pressed_d <= w_pressed;
      r_long_evt  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_out_n <= C_OUT_DEASSERTED;
          // Edge-triggered: a level still held from LOCKOUT never starts a pulse.
          if (w_rise && bus.BtnEnable) begin
            r_state <= ST_PULSE;
            r_ms    <= '0;
            r_lp    <= '0;
            r_out_n <= C_OUT_ASSERTED;
          end
        end

        ST_PULSE: begin
          r_out_n <= C_OUT_ASSERTED;
          if (w_long_hit) begin
            // Long press beats minimum-pulse expiry in the same cycle.
            r_state    <= ST_LONG;
            r_long_evt <= 1'b1;
            r_lp       <= w_lp_next;
            r_ms       <= '0;
          end else begin
            r_ms <= w_ms_next;
            r_lp <= w_pressed ? w_lp_next : '0;
            if (w_ms_next == C_PULSE_END) begin
              r_ms <= '0;
              if (w_pressed) begin
                r_state <= ST_HELD;
              end else begin
                r_state <= ST_LOCKOUT;
                r_out_n <= C_OUT_DEASSERTED;
              end
            end
          end
        end

        ST_HELD: begin
          r_out_n <= C_OUT_ASSERTED;
          if (!w_pressed) begin
            r_state <= ST_LOCKOUT;
            r_ms    <= '0;
            r_lp    <= '0;
            r_out_n <= C_OUT_DEASSERTED;
          end else if (w_long_hit) begin
            r_state    <= ST_LONG;
            r_long_evt <= 1'b1;
            r_lp       <= w_lp_next;
          end else begin
            r_lp <= w_lp_next;
          end
        end

        ST_LONG: begin
          r_out_n <= C_OUT_ASSERTED;
          if (!w_pressed) begin
            r_state <= ST_LOCKOUT;
            r_ms    <= '0;
            r_lp    <= '0;
            r_out_n <= C_OUT_DEASSERTED;
          end
        end

        ST_LOCKOUT: begin
          r_out_n <= C_OUT_DEASSERTED;
          r_ms    <= w_ms_next;
          if (w_ms_next == C_LOCKOUT_END) begin
            r_state <= ST_IDLE;
            r_ms    <= '0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ms    <= '0;
          r_lp    <= '0;
          r_out_n <= C_OUT_DEASSERTED;
        end
      endcase
    end
  end

  assign bus.PowerButtonOut_ox = r_out_n;
  assign bus.LongPressEvt      = r_long_evt;
  assign bus.BtnPressedDb      = w_pressed;
  assign bus.FsmState          = r_state;

endmodule
`default_nettype wire
